// File: rtl/alu_exec_unit.sv
// Execution responder for the CPU control FSM: captures operands on en_in, computes
// single-cycle ops or an iterative shift-add multiply, then pulses en_out once.
//
// state | meaning
// IDLE  | waiting for en_in; operands captured on the start pulse
// EXEC  | single-cycle op; result registered on the exit edge
// MUL   | shift-add iterations, then one cycle to register the product
// DONE  | en_out high for exactly this cycle
module alu_exec_unit #(
   parameter int DW = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_in,
   input  logic [3:0]    alu_func,
   input  logic          alu_in_sel,
   input  logic [DW-1:0] rd_data,
   input  logic [DW-1:0] rs_data,
   input  logic [DW-1:0] offset,
   output logic [DW-1:0] alu_out,
   output logic          en_out,
   output logic          busy,
   output logic          zero
);

   localparam int CW = $clog2(DW) + 1;
   localparam logic [SW:0] DW_L = (SW+1)'(DW);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [DW-1:0]   r_a, r_b, r_acc, r_mcand, r_mplier;
   logic [3:0]      r_func;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   w_b_sel, w_result;
   logic [SW-1:0]   w_shamt;
   logic [SW:0]     w_rot_back;

   assign w_b_sel    = alu_in_sel ? rs_data : offset;
   assign w_shamt    = r_b[SW-1:0];
   // Right-shift by DW (amount 0) yields zero, so rotate-by-0 returns A unchanged.
   assign w_rot_back = DW_L - {1'b0, w_shamt};

   always_comb begin
      w_result = r_b;
      case (r_func)
         4'b0000: w_result = r_b;
         4'b0001: w_result = r_a + r_b;
         4'b0010: w_result = r_a - r_b;
         4'b0011: w_result = r_a & r_b;
         4'b0100: w_result = r_a | r_b;
         4'b0101: w_result = r_a << w_shamt;
         4'b0110: w_result = r_a >> w_shamt;
         4'b1000: begin
            if (r_a > r_b)       w_result = {{(DW-1){1'b0}}, 1'b1};
            else if (r_a == r_b) w_result = '0;
            else                 w_result = '1;
         end
         4'b1001: w_result = (r_a << w_shamt) | (r_a >> w_rot_back);
         4'b1010: w_result = r_a ^ r_b;
         default: w_result = r_b;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (en_in) w_next = (alu_func == 4'b0111) ? S_MUL : S_EXEC;
         S_EXEC:  w_next = S_DONE;
         S_MUL:   if (r_cnt == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign en_out = (r_state == S_DONE);
   assign busy   = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_func   <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         alu_out  <= '0;
         zero     <= 1'b1;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (en_in) begin
                  r_a      <= rd_data;
                  r_b      <= w_b_sel;
                  r_func   <= alu_func;
                  r_acc    <= '0;
                  r_mcand  <= rd_data;
                  r_mplier <= w_b_sel;
                  r_cnt    <= CW'(DW);
               end
            end
            S_EXEC: begin
               alu_out <= w_result;
               zero    <= (w_result == '0);
            end
            S_MUL: begin
               // DW iteration cycles, then one terminal-count cycle that writes the product.
               if (r_cnt != '0) begin
                  if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt - CW'(1);
               end else begin
                  alu_out <= r_acc;
                  zero    <= (r_acc == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (DW=8): latency, results, zero flag,
// busy window, ignored start while busy, and reset abort.
module tb_alu_exec_unit;

   logic       clk;
   logic       rst;
   logic       en_in;
   logic [3:0] alu_func;
   logic       alu_in_sel;
   logic [7:0] rd_data, rs_data, offset;
   logic [7:0] alu_out;
   logic       en_out, busy, zero;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   int pulses;
   int first_c;

   alu_exec_unit #(.DW(8), .SW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_in      (en_in),
      .alu_func   (alu_func),
      .alu_in_sel (alu_in_sel),
      .rd_data    (rd_data),
      .rs_data    (rs_data),
      .offset     (offset),
      .alu_out    (alu_out),
      .en_out     (en_out),
      .busy       (busy),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start pulse; returns at the falling edge of cycle T+1.
   task automatic start(input logic [3:0] f, input logic sel,
                        input logic [7:0] rd, input logic [7:0] rs, input logic [7:0] off);
      @(negedge clk);
      alu_func = f; alu_in_sel = sel; rd_data = rd; rs_data = rs; offset = off; en_in = 1'b1;
      @(negedge clk);
      en_in = 1'b0; rd_data = 8'hAA; rs_data = 8'h55; offset = 8'h3C; alu_func = 4'b0000;
   endtask

   task automatic wait_done(input int limit, output int l);
      l = 1;
      while (en_out !== 1'b1 && l < limit) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic op(input string tag, input logic [3:0] f, input logic sel,
                     input logic [7:0] rd, input logic [7:0] rs, input logic [7:0] off,
                     input logic [7:0] exp, input int exp_lat);
      int l;
      start(f, sel, rd, rs, off);
      wait_done(30, l);
      check({tag, " latency"}, l, exp_lat);
      check({tag, " alu_out"}, alu_out, exp);
      check({tag, " zero"}, zero, (exp == 8'h00));
      @(negedge clk);
      check({tag, " en_out single"}, en_out, 1'b0);
   endtask

   initial begin
      rst = 1'b0; en_in = 1'b0; alu_func = 4'h0; alu_in_sel = 1'b0;
      rd_data = 8'h00; rs_data = 8'h00; offset = 8'h00;
      repeat (2) @(negedge clk);
      check("reset alu_out", alu_out, 8'h00);
      check("reset zero", zero, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset en_out", en_out, 1'b0);
      rst = 1'b1;

      // add with offset operand, cycle-by-cycle handshake
      start(4'b0001, 1'b0, 8'h12, 8'hEE, 8'h05);
      check("add T+1 busy", busy, 1'b1);
      check("add T+1 en_out", en_out, 1'b0);
      check("add T+1 alu_out held", alu_out, 8'h00);
      @(negedge clk);
      check("add T+2 en_out", en_out, 1'b1);
      check("add T+2 busy", busy, 1'b1);
      check("add alu_out", alu_out, 8'h17);
      check("add zero", zero, 1'b0);
      @(negedge clk);
      check("add T+3 en_out", en_out, 1'b0);
      check("add T+3 busy", busy, 1'b0);
      check("add T+3 alu_out held", alu_out, 8'h17);

      start(4'b0010, 1'b1, 8'h05, 8'h07, 8'h00);
      check("sub capture keeps alu_out", alu_out, 8'h17);
      wait_done(30, lat);
      check("sub latency", lat, 2);
      check("sub alu_out", alu_out, 8'hFE);
      @(negedge clk);

      op("cmp eq",   4'b1000, 1'b1, 8'h33, 8'h33, 8'h00, 8'h00, 2);
      op("cmp gt",   4'b1000, 1'b1, 8'h40, 8'h10, 8'h00, 8'h01, 2);
      op("cmp lt",   4'b1000, 1'b1, 8'h10, 8'h40, 8'h00, 8'hFF, 2);
      op("mul 13x11", 4'b0111, 1'b1, 8'd13, 8'd11, 8'h00, 8'h8F, 10);
      op("mul ovf",  4'b0111, 1'b1, 8'h20, 8'h10, 8'h00, 8'h00, 10);
      op("rotl",     4'b1001, 1'b1, 8'h81, 8'h0B, 8'h00, 8'h0C, 2);
      op("shl",      4'b0101, 1'b1, 8'h81, 8'h0B, 8'h00, 8'h08, 2);
      op("shr",      4'b0110, 1'b1, 8'h81, 8'h0B, 8'h00, 8'h10, 2);
      op("shl amt0", 4'b0101, 1'b1, 8'h5A, 8'h08, 8'h00, 8'h5A, 2);
      op("rotl amt0", 4'b1001, 1'b1, 8'hC3, 8'hF8, 8'h00, 8'hC3, 2);
      op("and",      4'b0011, 1'b0, 8'hF0, 8'h00, 8'h3C, 8'h30, 2);
      op("or",       4'b0100, 1'b0, 8'hF0, 8'h00, 8'h3C, 8'hFC, 2);
      op("xor",      4'b1010, 1'b1, 8'hFF, 8'h0F, 8'h00, 8'hF0, 2);
      op("pass",     4'b0000, 1'b0, 8'h11, 8'h22, 8'h77, 8'h77, 2);
      op("pass 1111", 4'b1111, 1'b1, 8'h11, 8'h99, 8'h00, 8'h99, 2);
      op("add wrap", 4'b0001, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 2);

      // start pulse during MUL must be ignored
      start(4'b0111, 1'b1, 8'd7, 8'd9, 8'h00);
      pulses = 0; first_c = 0;
      for (int c = 1; c <= 14; c++) begin
         if (en_out === 1'b1) begin
            pulses++;
            if (first_c == 0) first_c = c;
         end
         if (c == 5) check("mul busy mid", busy, 1'b1);
         if (c == 3) begin
            en_in = 1'b1; alu_func = 4'b0001; alu_in_sel = 1'b1; rd_data = 8'h01; rs_data = 8'h01;
         end
         if (c == 4) en_in = 1'b0;
         @(negedge clk);
      end
      check("busy-ignore pulse count", pulses, 1);
      check("busy-ignore pulse cycle", first_c, 10);
      check("busy-ignore alu_out", alu_out, 8'h3F);

      // reset during MUL aborts without completion
      start(4'b0111, 1'b1, 8'd13, 8'd11, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort alu_out", alu_out, 8'h00);
      check("abort busy", busy, 1'b0);
      check("abort en_out", en_out, 1'b0);
      check("abort zero", zero, 1'b1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (en_out === 1'b1) pulses++;
         if (i == 2) rst = 1'b1;
      end
      check("abort no en_out", pulses, 0);
      op("add after reset", 4'b0001, 1'b1, 8'h40, 8'h01, 8'h00, 8'h41, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side responder to the CPU control FSM.
- Captures operands when the controller pulses the register-file/ALU enable, and computes the function selected by alu_func. Some ops take one cycle; multiply is iterative.
- Returns a one-cycle completion pulse that drives the controller's en2 input. The result is held stable on alu_out for the following Write_back register write.

Parameters:
DW, 8, datapath width (register, offset and result width)
SW, 3, shift-amount width; must equal log2(DW)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
en_in  input  1  start pulse (connected to en_rf_pulse), one cycle wide
alu_func  input  4  operation select, sampled with en_in
alu_in_sel  input  1  B operand source: 1 = rs_data, 0 = offset; sampled with en_in
rd_data  input  DW  A operand (Rd register value)
rs_data  input  DW  Rs register value
offset  input  DW  immediate field from instruction register
alu_out  output  DW  registered result, held until next completion
en_out  output  1  completion pulse (to controller en2)
busy  output  1  high from capture until completion cycle inclusive
zero  output  1  registered: alu_out == 0, updated with alu_out

Behaviour:
- Reset (rst low, asynchronous):
  - alu_out = 0, en_out = 0, busy = 0, zero = 1.
  - State = IDLE; internal A, B, func and multiply registers cleared.
  - Reset mid-operation aborts the operation; no en_out is produced for it.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - en_in high at edge T: latch A = rd_data, B = (alu_in_sel ? rs_data : offset), func = alu_func.
  - Next state is MUL if func = 0111, else EXEC.
  - en_in low: stay in IDLE.
- EXEC, one cycle: compute result, register into alu_out/zero at the edge leaving EXEC, then go to DONE.
- MUL, shift-add, exactly DW cycles:
  - Each cycle: if multiplier bit 0 = 1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
  - After DW cycles, alu_out = acc[DW-1:0] (low DW bits, overflow discarded), then go to DONE.
- DONE:
  - en_out = 1 for exactly this cycle, busy = 1; next state is IDLE.
- Latency from the en_in cycle T to the en_out cycle:
  - Single-cycle ops: en_out in cycle T+2.
  - MUL: en_out in cycle T+DW+2.
- busy:
  - Asserts the cycle after capture and deasserts the cycle after DONE.
  - en_in while busy (states EXEC/MUL/DONE) is ignored; latched operands are unchanged.
- alu_out holds its value from completion until the next completion. It does not change on capture, so Write_back reads a stable value.
- Function encoding (A = latched Rd, B = latched operand; all arithmetic modulo 2^DW):
  - 0000 pass: B
  - 0001 add: A+B
  - 0010 sub: A-B (two's-complement wrap)
  - 0011 and: A&B
  - 0100 or: A|B
  - 0101 shl: A << B[SW-1:0], zero fill
  - 0110 shr: A >> B[SW-1:0], logical, zero fill
  - 0111 mul: A*B, low DW bits
  - 1000 cmp, unsigned: 1 if A>B; 0 if A==B; all-ones if A<B
  - 1001 rotl: A rotated left by B[SW-1:0]
  - 1010 xor: A^B
  - 1011..1111: pass B
- Shift amount 0 yields A unchanged. Upper bits of B above SW are ignored for shifts/rotate.
- Combinational inputs rd_data/rs_data/offset may change after capture without effect.

Test Plan:
- Reset, then en_in with func=0001, sel=0, rd_data=0x12, offset=0x05 -> en_out single pulse at T+2, alu_out=0x17, zero=0, busy high T+1..T+2.
- func=0010, sel=1, rd_data=0x05, rs_data=0x07 -> alu_out=0xFE; func=1000 with equal operands 0x33/0x33 -> alu_out=0x00, zero=1.
- func=0111, sel=1, rd_data=13, rs_data=11 -> en_out at T+10 (DW=8), alu_out=143 (0x8F); 0x20*0x10 -> alu_out=0x00 (overflow discarded).
- func=1001, rd_data=0x81, rs_data=0x0B (amount 3) -> alu_out=0x0C; func=0101 same operands -> 0x08; func=0110 -> 0x10.
- Start MUL, pulse en_in with func=0001 at T+3 -> ignored; only one en_out at T+10 carrying the MUL result.
- Start MUL, drop rst at T+4 -> alu_out=0, busy=0, en_out never asserted. After release, a new add completes normally at T'+2.
